// File: rtl/cnn_pixel_streamer.sv
// Streams an IX x IY image from a 1-cycle-latency frame memory onto the
// valid/pixel bus of the conv core, with row/column sidebands and frame markers.
module cnn_pixel_streamer #(
   parameter  int I_F_BW    = 8,
   parameter  int IX        = 28,
   parameter  int IY        = 28,
   parameter  int ADDR_BW   = 10,
   parameter  int BASE_ADDR = 0,
   localparam int ROW_W     = (IY > 1) ? $clog2(IY) : 1,
   localparam int COL_W     = (IX > 1) ? $clog2(IX) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_start,
   input  logic               i_hold,
   output logic               o_mem_en,
   output logic [ADDR_BW-1:0] o_mem_addr,
   input  logic [I_F_BW-1:0]  i_mem_rdata,
   output logic               o_valid,
   output logic [I_F_BW-1:0]  o_pixel,
   output logic [ROW_W-1:0]   o_row,
   output logic [COL_W-1:0]   o_col,
   output logic               o_sof,
   output logic               o_eol,
   output logic               o_eof,
   output logic               o_busy,
   output logic               o_done
);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_BW-1:0] BASE_A   = ADDR_BW'(BASE_ADDR);
   localparam logic [ADDR_BW-1:0] LAST_A   = ADDR_BW'(BASE_ADDR + IX * IY - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(IY - 1);
   localparam logic [COL_W-1:0]   COL_LAST = COL_W'(IX - 1);

   state_t              state_q, state_d;
   logic [ADDR_BW-1:0]  addr_q, addr_d;
   logic                rd_pend_p1_q, rd_pend_p1_d;
   logic                vld_p2_q, vld_p2_d;
   logic [I_F_BW-1:0]   pixel_q, pixel_d;
   logic [ROW_W-1:0]    row_q, row_d, nrow_q, nrow_d;
   logic [COL_W-1:0]    col_q, col_d, ncol_q, ncol_d;
   logic                sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
   logic                mem_en;

   assign mem_en = (state_q == S_STREAM) && !i_hold;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rd_pend_p1_d = mem_en;
      vld_p2_d     = rd_pend_p1_q;
      pixel_d      = pixel_q;
      row_d        = row_q;
      col_d        = col_q;
      nrow_d       = nrow_q;
      ncol_d       = ncol_q;
      sof_d        = 1'b0;
      eol_d        = 1'b0;
      eof_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_STREAM;
               addr_d  = BASE_A;
            end
         end
         S_STREAM: begin
            if (mem_en) begin
               addr_d = addr_q + 1'b1;
               if (addr_q == LAST_A) begin
                  state_d = S_DRAIN;
                  addr_d  = BASE_A;
               end
            end
         end
         S_DRAIN: begin
            if (eof_q) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      // nrow/ncol name the position of the pixel arriving from memory next
      if (rd_pend_p1_q) begin
         pixel_d = i_mem_rdata;
         row_d   = nrow_q;
         col_d   = ncol_q;
         sof_d   = (nrow_q == '0) && (ncol_q == '0);
         eol_d   = (ncol_q == COL_LAST);
         eof_d   = (ncol_q == COL_LAST) && (nrow_q == ROW_LAST);
         if (ncol_q == COL_LAST) begin
            ncol_d = '0;
            nrow_d = (nrow_q == ROW_LAST) ? '0 : nrow_q + 1'b1;
         end else begin
            ncol_d = ncol_q + 1'b1;
         end
      end else if (eof_q) begin
         row_d = '0;
         col_d = '0;
      end
   end

   // p1: read issued last cycle; p2: registered pixel and sidebands
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= BASE_A;
         rd_pend_p1_q <= 1'b0;
         vld_p2_q     <= 1'b0;
         pixel_q      <= '0;
         row_q        <= '0;
         col_q        <= '0;
         nrow_q       <= '0;
         ncol_q       <= '0;
         sof_q        <= 1'b0;
         eol_q        <= 1'b0;
         eof_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rd_pend_p1_q <= rd_pend_p1_d;
         vld_p2_q     <= vld_p2_d;
         pixel_q      <= pixel_d;
         row_q        <= row_d;
         col_q        <= col_d;
         nrow_q       <= nrow_d;
         ncol_q       <= ncol_d;
         sof_q        <= sof_d;
         eol_q        <= eol_d;
         eof_q        <= eof_d;
      end
   end

   assign o_mem_en   = mem_en;
   assign o_mem_addr = addr_q;
   assign o_valid    = vld_p2_q;
   assign o_pixel    = pixel_q;
   assign o_row      = row_q;
   assign o_col      = col_q;
   assign o_sof      = sof_q;
   assign o_eol      = eol_q;
   assign o_eof      = eof_q;
   assign o_busy     = (state_q == S_STREAM) || (state_q == S_DRAIN);
   assign o_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Randomized bench for cnn_pixel_streamer: a transaction-level frame model checks
// every cycle, plus a small 5x3 instance at a non-zero base address.
module tb_cnn_pixel_streamer;

   localparam int IX = 28, IY = 28, N = IX * IY, BASE = 0;
   localparam int SIX = 5, SIY = 3, SN = SIX * SIY, SBASE = 100;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic i_start = 1'b0, i_hold = 1'b0;
   logic mem_en, valid, sof, eol, eof, busy, done;
   logic [9:0] mem_addr;
   logic [7:0] rdata = 8'd0, pixel;
   logic [4:0] row, col;
   logic [7:0] mem [0:1023];

   logic s_start = 1'b0;
   logic s_en, s_valid, s_sof, s_eol, s_eof, s_busy, s_done;
   logic [9:0] s_addr;
   logic [7:0] s_rdata = 8'd0, s_pixel;
   logic [1:0] s_row;
   logic [2:0] s_col;
   logic [7:0] smem [0:1023];

   always #5 clk = ~clk;

   cnn_pixel_streamer #(.I_F_BW(8), .IX(IX), .IY(IY), .ADDR_BW(10), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_hold(i_hold),
      .o_mem_en(mem_en), .o_mem_addr(mem_addr), .i_mem_rdata(rdata),
      .o_valid(valid), .o_pixel(pixel), .o_row(row), .o_col(col),
      .o_sof(sof), .o_eol(eol), .o_eof(eof), .o_busy(busy), .o_done(done));

   cnn_pixel_streamer #(.I_F_BW(8), .IX(SIX), .IY(SIY), .ADDR_BW(10), .BASE_ADDR(SBASE)) dut_s (
      .clk(clk), .reset_n(reset_n), .i_start(s_start), .i_hold(1'b0),
      .o_mem_en(s_en), .o_mem_addr(s_addr), .i_mem_rdata(s_rdata),
      .o_valid(s_valid), .o_pixel(s_pixel), .o_row(s_row), .o_col(s_col),
      .o_sof(s_sof), .o_eol(s_eol), .o_eof(s_eof), .o_busy(s_busy), .o_done(s_done));

   always @(posedge clk) if (mem_en) rdata <= mem[mem_addr];
   always @(posedge clk) if (s_en) s_rdata <= smem[s_addr];

   int n_vec = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame model: a frame reads N consecutive addresses, one per non-held cycle;
   // each read reappears on the pixel bus two cycles later; done follows the last pixel.
   bit m_in_frame = 0, m_reading = 0, m_done_now = 0, vp0 = 0, vp1 = 0;
   int m_reads = 0, m_emit = 0;

   always @(negedge clk) begin
      bit exp_en, exp_v, was_busy, was_done, nd;
      if (!reset_n) begin
         chk("rst_valid", valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_mem_en", mem_en, 0);
         chk("rst_addr", mem_addr, BASE);
         chk("rst_flags", {sof, eol, eof}, 0);
         chk("rst_pixel", pixel, 0);
         m_in_frame = 0; m_reading = 0; m_done_now = 0;
         vp0 = 0; vp1 = 0; m_reads = 0; m_emit = 0;
      end else begin
         exp_en = m_reading && !i_hold;
         exp_v  = vp1;
         chk("mem_en", mem_en, exp_en);
         chk("valid", valid, exp_v);
         chk("busy", busy, m_in_frame);
         chk("done", done, m_done_now);
         if (m_reading) chk("addr", mem_addr, BASE + m_reads);
         if (exp_v && valid) begin
            chk("pixel", pixel, mem[BASE + m_emit]);
            chk("row", row, m_emit / IX);
            chk("col", col, m_emit % IX);
            chk("sof", sof, m_emit == 0);
            chk("eol", eol, (m_emit % IX) == IX - 1);
            chk("eof", eof, m_emit == N - 1);
         end else begin
            chk("flags_idle", {sof, eol, eof}, 0);
         end
         was_busy = m_in_frame;
         was_done = m_done_now;
         nd = 0;
         vp1 = vp0;
         vp0 = exp_en;
         if (exp_en) begin
            m_reads++;
            if (m_reads == N) m_reading = 0;
         end
         if (exp_v) begin
            m_emit++;
            if (m_emit == N) begin m_in_frame = 0; nd = 1; end
         end
         if (!was_busy && !was_done && i_start) begin
            m_in_frame = 1; m_reading = 1; m_reads = 0; m_emit = 0;
         end
         m_done_now = nd;
      end
   end

   // Small-instance checker: addresses SBASE.., pixels in raster order.
   int s_k = 0, s_r = 0, s_dones = 0;
   always @(negedge clk) begin
      if (reset_n) begin
         if (s_en) begin
            chk("s_addr", s_addr, SBASE + s_r);
            s_r++;
         end
         if (s_valid) begin
            chk("s_pixel", s_pixel, smem[SBASE + s_k]);
            chk("s_row", s_row, s_k / SIX);
            chk("s_col", s_col, s_k % SIX);
            chk("s_sof", s_sof, s_k == 0);
            chk("s_eol", s_eol, (s_k % SIX) == SIX - 1);
            chk("s_eof", s_eof, s_k == SN - 1);
            s_k++;
         end
         if (s_done) s_dones++;
      end
   end

   int p0, er, ec, neof, nval;

   function automatic bit hv(int c, int lo, int hi, bit rnd);
      return (c >= lo && c <= hi) || (rnd && $urandom_range(0, 3) == 0);
   endfunction

   // Cycle 0 is the cycle i_start is high; returns first-valid and done cycles.
   task automatic run_frame(input int hold_lo, input int hold_hi, input bit rnd,
                            input int mid_start, input int reset_at, input bit start_in_done,
                            output int fv, output int dc);
      bit aborted = 0;
      fv = -1; dc = -1; p0 = -1; er = -1; ec = -1; neof = 0; nval = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         i_start = (c == 0) || (c == mid_start);
         i_hold  = hv(c, hold_lo, hold_hi, rnd);
         if (reset_at >= 0 && nval == reset_at) begin
            reset_n = 1'b0;
            aborted = 1;
         end
         @(negedge clk);
         if (aborted) break;
         if (valid) begin
            if (fv < 0) fv = c;
            if (nval == 0) p0 = pixel;
            if (eof) begin neof++; er = row; ec = col; end
            nval++;
         end
         if (done) begin dc = c; break; end
      end
      if (aborted) begin
         repeat (2) @(posedge clk);
         #1;
         reset_n = 1'b1;
         i_start = 1'b0;
         i_hold  = 1'b0;
         repeat (6) @(posedge clk);
      end else begin
         if (dc < 0) chk("frame_timeout", 0, 1);
         #1;
         i_start = start_in_done;
         i_hold  = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fv, dc;
      for (int a = 0; a < 1024; a++) begin
         mem[a]  = 8'((a + 1) & 255);
         smem[a] = 8'((a * 7 + 3) & 255);
      end
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1 s_start = 1'b1;
      @(posedge clk);
      #1 s_start = 1'b0;

      run_frame(-1, -1, 0, -1, -1, 0, fv, dc);
      chk("f1_first_valid", fv, 3);
      chk("f1_done_cycle", dc, 787);
      chk("f1_pixel0", p0, 1);
      chk("f1_eof_row", er, 27);
      chk("f1_eof_col", ec, 27);
      chk("f1_eof_count", neof, 1);
      chk("f1_valid_count", nval, N);
      chk("s_valid_count", s_k, SN);
      chk("s_read_count", s_r, SN);
      chk("s_done_count", s_dones, 1);

      run_frame(10, 14, 0, 100, -1, 1, fv, dc);
      chk("f2_first_valid", fv, 3);
      chk("f2_done_cycle", dc, 792);
      chk("f2_valid_count", nval, N);

      run_frame(-1, -1, 0, -1, -1, 0, fv, dc);
      chk("f3_first_valid", fv, 3);
      chk("f3_pixel0", p0, 1);
      chk("f3_done_cycle", dc, 787);

      run_frame(784, 786, 0, -1, -1, 0, fv, dc);
      chk("f4_done_cycle", dc, 790);
      chk("f4_eof_count", neof, 1);

      run_frame(0, 3, 0, -1, -1, 0, fv, dc);
      chk("f5_first_valid", fv, 6);
      chk("f5_done_cycle", dc, 790);

      for (int a = 0; a < N; a++) mem[BASE + a] = 8'($urandom_range(0, 255));
      run_frame(-1, -1, 1, -1, -1, 0, fv, dc);
      chk("f6_valid_count", nval, N);
      chk("f6_eof_count", neof, 1);

      run_frame(-1, -1, 0, -1, 400, 0, fv, dc);
      chk("f7_no_done", dc, -1);
      chk("f7_valid_before_abort", nval, 400);

      run_frame(-1, -1, 0, -1, -1, 0, fv, dc);
      chk("f8_first_valid", fv, 3);
      chk("f8_pixel0", p0, mem[BASE]);
      chk("f8_done_cycle", dc, 787);

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cnn_pixel_streamer.md
Name: cnn_pixel_streamer

Overview:
- Transmit side of the CNN pixel-input interface (valid/pixel stream).
- Reads an IX x IY 8-bit image from a synchronous-read frame memory (1-cycle read latency).
- Emits it in raster order on the valid/pixel bus that feeds the line-buffer/5x5 window conv core, with row/column sidebands and frame start/end markers.
- Replaces bench-driven pixel loops in system builds.

Parameters:
- I_F_BW, 8, pixel width in bits
- IX, 28, image width (columns)
- IY, 28, image height (rows)
- ADDR_BW, 10, memory address width; must satisfy 2^ADDR_BW >= IX*IY
- BASE_ADDR, 0, memory address of pixel (0,0)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- i_start  in  1  start-frame request; sampled only in IDLE
- i_hold  in  1  gap request; while high, no new memory read is issued
- o_mem_en  out  1  memory read enable; combinational = (state==STREAM) && !i_hold
- o_mem_addr  out  ADDR_BW  read address, registered counter
- i_mem_rdata  in  I_F_BW  read data, valid the cycle after o_mem_en
- o_valid  out  1  pixel valid to the conv core
- o_pixel  out  I_F_BW  pixel data, registered
- o_row  out  clog2(IY)  row of the current o_pixel
- o_col  out  clog2(IX)  column of the current o_pixel
- o_sof  out  1  high with pixel (0,0)
- o_eol  out  1  high with every pixel where col = IX-1
- o_eof  out  1  high with pixel (IY-1, IX-1)
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset (async, immediate): state=IDLE; o_mem_addr=BASE_ADDR; all flags, counters, o_pixel=0; any in-flight read discarded.
- FSM: IDLE -> STREAM on i_start=1.
- STREAM -> DRAIN after the read of address BASE_ADDR+IX*IY-1 is issued.
- DRAIN -> DONE once the last pixel has been emitted (o_eof cycle).
- DONE -> IDLE unconditionally after 1 cycle.
- i_start is ignored in STREAM, DRAIN and DONE; it is first accepted in the cycle after o_done.
- STREAM: each cycle with i_hold=0 issues one read (o_mem_en=1) and o_mem_addr increments at the clock edge. With i_hold=1, o_mem_addr holds and no read is issued.
- Pipeline: rd_pend <= o_mem_en; then o_valid <= rd_pend, with o_pixel <= i_mem_rdata in the same edge. Outputs are fully registered.
- Latency: i_start sampled at the end of cycle 0 -> first o_mem_en in cycle 1 -> first o_valid in cycle 3.
- No hold: o_valid is continuous for IX*IY cycles (3..IX*IY+2); o_done is in cycle IX*IY+3.
- i_hold has 2-cycle effect latency on o_valid. The output pipeline never stalls: reads already issued always complete. The consumer has no backpressure.
- o_row/o_col/o_sof/o_eol/o_eof are generated from counters advanced on o_valid and are aligned with o_pixel.
- o_col wraps IX-1 -> 0 and increments o_row.
- After o_eof, o_row and o_col return to 0.
- o_row, o_col and the sideband flags are don't-care and held when o_valid=0; sideband flags are 0 when o_valid=0.
- o_busy: 1 from cycle 1 through the o_eof cycle inclusive; 0 in DONE.
- o_done: 1 only in the DONE cycle.
- i_hold=1 on the final read: DRAIN is not entered until that read is actually issued.
- i_start and i_hold both high in IDLE: the transition is taken; the first read waits until i_hold drops.
- reset_n low mid-frame: outputs clear asynchronously. No o_done is produced for an aborted frame. The next frame restarts at BASE_ADDR.

Test Plan:
- Frame memory holds mem[a] = (a+1) & 255, no hold, i_start pulse in cycle 0 -> o_valid high in cycles 3..786; pixel k = (k+1) & 255; o_sof at k=0; o_eol at k = 27, 55, ..., 783; o_eof at k=783 (row 27, col 27); o_done single pulse in cycle 787; o_busy 0 afterwards.
- i_hold high for cycles 10..14 -> o_valid low for exactly 5 cycles (12..16); pixel sequence unbroken, no duplicates or skips; o_done delayed by 5 cycles (cycle 792).
- i_start re-pulsed mid-frame and in the DONE cycle -> ignored; start in the cycle after o_done -> new frame, first o_valid 3 cycles later, pixel 0 = 1.
- reset_n pulsed low at pixel 400 -> o_valid, o_busy and sideband flags drop immediately; no o_done; a new i_start streams from pixel 0.
- IX=5, IY=3, BASE_ADDR=100 -> o_mem_addr runs 100..114; 15 valid pixels; o_eol at cols 4 of rows 0..2; o_eof at (2,4).
- Hold asserted in the same cycle as the final read would issue -> exactly one o_eof; o_done follows o_eof by one cycle.
